ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage. Consumes operands and op from ID/EX pipeline register outputs.
//  Stalls the front of the pipeline (ID/EX en, IF/ID en, PC) while computing.
//  Delivers one XLEN-bit result to the EX/MEM mux. Radix-2: one bit per cycle.
// PARAMETERS
//  XLEN  32  operand/result width; counter width = $clog2(XLEN)+1
// PORTS
//  clk           in   1     clock
//  rst           in   1     reset: synchronous, active-low
//  start         in   1     ID/EX holds a valid M-extension op
//  op            in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_val       in   XLEN  forwarded operand A (dividend/multiplicand)
//  rs2_val       in   XLEN  forwarded operand B (divisor/multiplier)
//  advance       in   1     EX instruction leaves stage this edge (ID/EX en && !other stall)
//  flush         in   1     branch/exception kill of EX instruction
//  stall         out  1     hold upstream stages and ID/EX
//  result_valid  out  1     result holds final value
//  result        out  XLEN  MUL: low word; MULH*: high word; DIV*: quotient; REM*: remainder
// BEHAVIOUR
//  States: IDLE, CALC, DONE. Reset (rst==0 at edge): state=IDLE, count=0, result=0, result_valid=0, internal regs=0.
//  stall = rst && start && !flush && (state!=DONE). Combinational, so it rises in the same cycle start rises.
//  IDLE & start & !flush: latch op, |rs1|, |rs2| (magnitudes per op signedness) and result sign flags.
//   DIV/REM with rs2==0 -> DONE directly: quotient=all ones, remainder=rs1_val.
//   DIV/REM signed with rs1==0x80000000 and rs2==-1 -> DONE directly: quotient=0x80000000, remainder=0.
//   Otherwise -> CALC with count=0.
//  CALC: one iteration per cycle, XLEN iterations; count==XLEN-1 -> DONE.
//   Multiply: 2*XLEN shift-add accumulator over unsigned magnitudes.
//   Divide: restoring shift-subtract; XLEN-bit quotient and remainder.
//  Sign fix on CALC->DONE transition:
//   product negated (2*XLEN) if signs differ (MULH: both signed; MULHSU: rs1 only; MUL: either form, low word identical).
//   quotient negated if signed op and signs differ; remainder takes dividend sign.
//  DONE: result_valid=1, result stable, stall=0. advance -> IDLE (result_valid=0 next cycle, result retains value).
//   !advance -> stay DONE; no restart even though start remains high.
//  Latency (normal): start seen cycle 0; stall high cycles 0..XLEN (XLEN+1 cycles); result_valid from cycle XLEN+1.
//  Latency (special case): stall 1 cycle; result_valid from cycle 1.
//  flush in any state: next state IDLE, result_valid=0, no result. Flush wins over start and advance in the same cycle.
//  rst mid-CALC or mid-DONE: returns to IDLE at that edge; all outputs take reset values.
//  Back-to-back ops: DONE+advance -> IDLE; a new start is accepted the following cycle (one IDLE cycle between ops).
//  start low in IDLE: stay IDLE, stall=0, result_valid=0. Operand changes during CALC are ignored (latched copies used).
//  All arithmetic is unsigned on magnitudes. Overflow in MUL low word wraps mod 2^XLEN.
// TESTING
//  MUL 7 x 0xFFFFFFFD -> result=0xFFFFFFEB, stall high exactly 33 cycles, result_valid cycle 33.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Each: 1 stall cycle.
//  DONE with advance=0 for 5 cycles: result_valid/result held, stall=0, no re-execution; advance=1 -> IDLE.
//  rst=0 at CALC count 10 -> IDLE, result=0, stall=0. flush at count 10 -> IDLE, valid never asserted.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 RV32M multiply/divide for the EX stage.
// Rev 1.0 -- one result bit per cycle; stalls the front end while busy.
`default_nettype none

module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            advance,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                valid_q, valid_d;

  logic                a_signed, b_signed, rs1_neg, rs2_neg, is_div;
  logic [XLEN-1:0]     rs1_mag, rs2_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_top;
  logic [XLEN+1:0]     div_diff;
  logic [2*XLEN-1:0]   div_shift, mul_next, div_next, acc_step, prod;
  logic [XLEN-1:0]     quot, rem, final_res;

  assign stall        = rst && start && !flush && (state_q != DONE);
  assign result_valid = valid_q;
  assign result       = result_q;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    is_div   = op[2];
    rs1_neg  = a_signed && rs1_val[XLEN-1];
    rs2_neg  = b_signed && rs2_val[XLEN-1];
    rs1_mag  = rs1_neg ? -rs1_val : rs1_val;
    rs2_mag  = rs2_neg ? -rs2_val : rs2_val;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
    div_shift = {acc_q[2*XLEN-2:0], 1'b0};
    div_top   = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = {1'b0, div_top} - {2'b00, b_q};
    div_next  = div_diff[XLEN+1] ? div_shift
                                 : {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};

    acc_step = op_q[2] ? div_next : mul_next;
    prod     = neg_q ? -acc_step : acc_step;
    quot     = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem      = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quot;
      default:                final_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    valid_d  = valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = rs1_mag;
          b_d     = rs2_mag;
          neg_d   = rs1_neg ^ rs2_neg;
          rneg_d  = rs1_neg;
          count_d = '0;
          if (is_div && (rs2_val == '0)) begin
            result_d = op[1] ? rs1_val : '1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (is_div && !op[0] && (rs1_val == MIN_NEG) && (rs2_val == '1)) begin
            result_d = op[1] ? '0 : MIN_NEG;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (is_div ? rs1_mag : rs2_mag)};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = acc_step;
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN-1)) begin
          result_d = final_res;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (advance) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A killed instruction must never deliver a result.
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed checks of ex_muldiv_unit against an arithmetic model.
`default_nettype none

module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        advance;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .advance      (advance),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int expected_stall(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0)) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] exp;
    int          cyc;
    bit          got;
    exp = model(o, a, b);
    cyc = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; advance = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      if (stall) cyc++;
      @(negedge clk);
      rs1_val = $urandom;
      rs2_val = $urandom;
    end
    check("result_valid_timeout", 64'(got), 64'd1);
    check("result", 64'(result), 64'(exp));
    check("stall_cycles", 64'(cyc), 64'(expected_stall(o, a, b)));
    check("stall_in_done", 64'(stall), 64'd0);
    if (hold) begin
      repeat (5) begin
        @(negedge clk);
        #1;
        check("hold_valid", 64'(result_valid), 64'd1);
        check("hold_result", 64'(result), 64'(exp));
        check("hold_stall", 64'(stall), 64'd0);
      end
    end
    @(negedge clk);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    start = 1'b0;
    #1;
    check("valid_after_advance", 64'(result_valid), 64'd0);
    check("result_retained", 64'(result), 64'(exp));
  endtask

  // Abort an operation after count reaches 10 (11 cycles after start is seen).
  task automatic kill_mid_calc(input bit use_reset);
    bit seen_valid;
    seen_valid = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_val = 32'd12345; rs2_val = 32'd678; advance = 1'b0;
    repeat (11) @(negedge clk);
    if (use_reset) rst = 1'b0;
    else           flush = 1'b1;
    #1;
    check("stall_during_kill", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("stall_after_kill", 64'(stall), 64'd0);
    check("valid_after_kill", 64'(result_valid), 64'd0);
    if (use_reset) check("result_after_reset", 64'(result), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (result_valid) seen_valid = 1'b1;
    end
    check("valid_never_after_kill", 64'(seen_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b0; start = 1'b0; op = 3'd0; rs1_val = '0; rs2_val = '0;
    advance = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", 64'(result), 64'd0);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("idle_no_start_stall", 64'(stall), 64'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = -ra;
        default: ;
      endcase
      run_op(ro, ra, rb, 1'b0);
    end

    run_op(3'd7, 32'd100, 32'd7, 1'b0);
    kill_mid_calc(1'b0);
    kill_mid_calc(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
